div_radix2: RTL and testbench
=============================

# div_radix2

Iterative radix-2 restoring divider for the execute stage. It is the counterpart of the carry-save multiplier path: the multiplier compresses partial products into a product, and this block peels a quotient and remainder back out of a dividend, one bit per cycle. It sits beside the multiplier in the EXU and serves DIV/MOD (signed and unsigned) through a valid/ready handshake on both sides. It supports a pipeline flush.

## Interface
Parameters:
- WIDTH, 32, operand, quotient and remainder width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  abandons any in-flight or completed operation.
- in_valid  in  1  request valid.
- in_ready  out  1  divider can accept a request (state IDLE).
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned.
- in_dividend  in  WIDTH  dividend.
- in_divisor  in  WIDTH  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- out_quotient  out  WIDTH  quotient.
- out_remainder  out  WIDTH  remainder.

## Operation
- States:
  - IDLE -> CALC on accept (in_valid & in_ready & ~flush).
  - CALC -> FIX after WIDTH iterations.
  - FIX -> DONE.
  - DONE -> IDLE on out_valid & out_ready.
- On accept, latch the following:
  - the magnitudes |dividend| and |divisor| (only when in_signed; otherwise the raw operands);
  - sign_q = sign(dividend) XOR sign(divisor);
  - sign_r = sign(dividend);
  - the raw dividend;
  - a divisor-zero flag;
  - an iteration counter cleared to 0.
- CALC step, using a WIDTH+1-bit partial remainder R and shift register Q:
  - T = {R[WIDTH-1:0], Q[MSB]} − {0, divisor}.
  - If T is non-negative: R = T and shift 1 into Q; otherwise R = the shifted value and shift 0 into Q.
  - Increment the counter. Leave CALC when the counter reaches WIDTH−1 at the clock edge.
- FIX:
  - Negate Q if sign_q is set; negate R if sign_r is set (signed ops only).
  - Register the results into out_quotient and out_remainder.
- Special results are decided here, overriding the FIX result:
  - Divisor zero: quotient = all ones, remainder = raw dividend (both signednesses).
  - Signed overflow (dividend = 1 followed by zeros, divisor = all ones): quotient = dividend, remainder = 0. This falls out of the magnitude arithmetic, but it is a mandatory check.
- Remainder sign always equals the dividend's sign (truncating division).
- DONE:
  - out_valid = 1; results are held stable until out_ready.
  - in_ready = 0; no request is accepted in the completing cycle.
- flush:
  - From any state, go to IDLE on the next edge and drop out_valid.
  - A result in DONE is discarded even if out_ready is high the same cycle.
  - in_valid is ignored in a flush cycle.
- in_ready = (state == IDLE), combinational from state.

## Timing
- Reset values:
  - state IDLE, in_ready 1;
  - out_valid 0;
  - out_quotient 0, out_remainder 0;
  - counter 0.
- Latency is fixed for all operands, including the special cases:
  - accept at edge 0;
  - CALC occupies edges 1..WIDTH;
  - FIX at edge WIDTH+1;
  - out_valid high from edge WIDTH+2 (34 cycles for WIDTH=32).
- Throughput is one operation per WIDTH+3 cycles at best. A new accept is possible in the cycle after the out handshake.
- Reset asserted mid-operation returns to the reset values immediately (asynchronous). No result appears afterwards.
- The subtractor is WIDTH+1 bits. It is the only long path and must close in one cycle.

## Structure
- Shared package div_pkg:
  - state encoding constants (IDLE, CALC, FIX, DONE);
  - DIV_WIDTH = 32;
  - divide-by-zero quotient constant (all ones).
- One sub-module, div_step: the combinational single-iteration restoring step.
  - Inputs R, the Q MSB and the divisor; outputs next R and the quotient bit.
  - Kept separate so a radix-4 variant can later instantiate two.
- Top module holds the FSM, counter, operand/sign latches, sign fix and output registers.

## Test plan
- Unsigned 100 / 7:
  - quotient 14, remainder 2;
  - out_valid exactly 34 cycles after accept;
  - in_ready low during those 34 cycles.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Divide by zero:
  - unsigned 5 / 0 -> quotient 0xFFFFFFFF, remainder 5;
  - signed −5 / 0 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFFB.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
  - Also unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Backpressure:
  - Hold out_ready low for 5 cycles; results and out_valid stay stable and in_ready stays 0.
  - Handshake, then issue a back-to-back request the next cycle; it is accepted.
- Flush and reset mid-operation:
  - flush at cycle 10 of CALC -> IDLE next cycle, no out_valid ever.
  - Same for rst_n pulsed low mid-CALC.
  - A fresh 9 / 3 afterwards yields quotient 3, remainder 0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 divider: FSM encoding, default width
// and the divide-by-zero quotient constant.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // All-ones quotient returned for a zero divisor.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the difference only
// when it is non-negative. Purely combinational so a radix-4 variant can
// chain two of these per cycle.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Trial subtraction on WIDTH+1 bits. The stored remainder is always below
  // the divisor, so the shifted value is below twice the divisor and the top
  // bit of the difference is a reliable sign; the result of either branch
  // then fits back into WIDTH bits.
  always_comb begin
    shifted = {r, q_msb};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    r_next  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider (DIV/MOD, signed and unsigned).
// Fixed latency: accept, WIDTH CALC cycles, one FIX cycle, then DONE.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// the result stays stable until out_ready. flush wins over both handshakes:
// in_valid is ignored and a DONE result is dropped even if out_ready is high.
module div_radix2
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [1:0]       dbg_state
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] r_q;          // partial remainder
  logic [WIDTH-1:0] q_q;          // dividend bits in, quotient bits out
  logic [WIDTH-1:0] divisor_q;    // divisor magnitude
  logic [WIDTH-1:0] dividend_q;   // raw dividend for the zero-divisor result
  logic             sign_q_q;
  logic             sign_r_q;
  logic             dvz_q;
  logic             ovf_q;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic [WIDTH-1:0] fix_quot, fix_rem;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign dbg_state = state_q;
  assign accept    = in_ready & in_valid & ~flush;

  // Operand magnitudes; unsigned requests pass through untouched.
  always_comb begin
    a_neg = in_signed & in_dividend[WIDTH-1];
    b_neg = in_signed & in_divisor[WIDTH-1];
    a_mag = a_neg ? (~in_dividend + 1'b1) : in_dividend;
    b_mag = b_neg ? (~in_divisor + 1'b1) : in_divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .q_msb   (q_q[WIDTH-1]),
    .divisor (divisor_q),
    .r_next  (step_r),
    .q_bit   (step_q)
  );

  // Sign correction and special-case override applied in FIX.
  always_comb begin
    fix_quot = sign_q_q ? (~q_q + 1'b1) : q_q;
    fix_rem  = sign_r_q ? (~r_q + 1'b1) : r_q;
    if (dvz_q) begin
      fix_quot = {WIDTH{1'b1}};
      fix_rem  = dividend_q;
    end else if (ovf_q) begin
      fix_quot = dividend_q;
      fix_rem  = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)             state_d = ST_CALC;
      ST_CALC: if (cnt_q == LAST_CNT)    state_d = ST_FIX;
      ST_FIX:                            state_d = ST_DONE;
      ST_DONE: if (out_ready)            state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Datapath: operand latch on accept, one step per CALC cycle, results in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      r_q           <= '0;
      q_q           <= '0;
      divisor_q     <= '0;
      dividend_q    <= '0;
      sign_q_q      <= 1'b0;
      sign_r_q      <= 1'b0;
      dvz_q         <= 1'b0;
      ovf_q         <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q      <= '0;
            r_q        <= '0;
            q_q        <= a_mag;
            divisor_q  <= b_mag;
            dividend_q <= in_dividend;
            sign_q_q   <= a_neg ^ b_neg;
            sign_r_q   <= a_neg;
            dvz_q      <= (in_divisor == '0);
            ovf_q      <= in_signed & (in_dividend == MIN_NEG) & (in_divisor == '1);
          end
        end
        ST_CALC: begin
          r_q   <= step_r;
          q_q   <= {q_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q + 1'b1;
        end
        ST_FIX: begin
          out_quotient  <= fix_quot;
          out_remainder <= fix_rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2. The driver pushes the hand-computed result
// of every request that should complete into exp_q; the monitor pops and
// compares on each output handshake, and also checks latency and in_ready
// while an operation is in flight.
module tb_div_radix2;

  localparam int W = 32;
  localparam int LATENCY = 34;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_signed = 1'b0;
  logic [W-1:0] in_dividend = '0;
  logic [W-1:0] in_divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic [1:0]   dbg_state;

  logic [2*W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  div_radix2 #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_signed     (in_signed),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   acc_edge = 0;
  logic busy = 1'b0;
  logic ir_bad = 1'b0;
  logic prev_ov = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy    = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (busy && in_ready) ir_bad = 1'b1;
      if (out_valid && !prev_ov) begin
        // out_valid set by edge cyc, so it is seen high at edge cyc+1.
        chk("latency", W'(cyc + 1 - acc_edge), W'(LATENCY));
        chk("in_ready_low_while_busy", {31'd0, ir_bad}, '0);
        busy = 1'b0;
      end
      prev_ov = out_valid;
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", out_quotient, '0);
          chk("unexpected_result_valid", {31'd0, out_valid}, '0);
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          chk("quotient", out_quotient, e[2*W-1:W]);
          chk("remainder", out_remainder, e[W-1:0]);
        end
      end
      if (flush) begin
        busy    = 1'b0;
        prev_ov = 1'b0;
      end else if (in_valid && in_ready) begin
        acc_edge = cyc + 1;
        busy     = 1'b1;
        ir_bad   = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic expect_result, output int waited);
    @(posedge clk); #2;
    in_signed   = sgn;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    if (expect_result) exp_q.push_back({q, r});
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", W'(exp_q.size()), '0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  int w;
  logic [W-1:0] held_q, held_r;

  initial begin
    // Reset state
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, '0);
    chk("reset_quotient", out_quotient, '0);
    chk("reset_remainder", out_remainder, '0);
    chk("reset_state", {30'd0, dbg_state}, '0);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);

    // Basic and sign cases
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1, w);
    drain();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1, w);
    drain();
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b1, w);
    drain();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b1, w);
    drain();

    // Divide by zero
    issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, w);
    drain();
    issue(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, w);
    drain();

    // Overflow and full-range unsigned
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, w);
    drain();
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, w);
    drain();

    // Backpressure: result held for 5 cycles, then back-to-back request
    out_ready = 1'b0;
    issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b1, w);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
      held_q = 32'd100;
      held_r = 32'd0;
      repeat (5) begin
        @(negedge clk);
        chk("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
        chk("bp_in_ready_low", {31'd0, in_ready}, '0);
        chk("bp_quotient_hold", out_quotient, held_q);
        chk("bp_remainder_hold", out_remainder, held_r);
      end
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    issue(1'b0, 32'd12345, 32'd100, 32'd123, 32'd45, 1'b1, w);
    chk("back_to_back_wait", W'(w), '0);
    drain();

    // Flush at cycle 10 of CALC
    issue(1'b0, 32'd77, 32'd5, 32'd0, 32'd0, 1'b0, w);
    idle_cycles(9);
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_state", {30'd0, dbg_state}, '0);
    chk("flush_out_valid", {31'd0, out_valid}, '0);
    idle_cycles(45);

    // Asynchronous reset mid-CALC
    issue(1'b0, 32'd77, 32'd5, 32'd0, 32'd0, 1'b0, w);
    idle_cycles(10);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, '0);
    chk("rst_quotient", out_quotient, '0);
    chk("rst_remainder", out_remainder, '0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(45);

    // Fresh operation afterwards
    issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b1, w);
    drain();
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
